// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   - parity mode constants
//   - receiver FSM state encoding
//   - baud counter sizing helpers
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Clocks per bit period.
    function automatic int baud_cnt_max(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

    // Width of a counter that runs 0..baud_cnt_max-1.
    function automatic int baud_cnt_width(input int clk_freq, input int bps);
        int w;
        w = $clog2(clk_freq / bps);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial line conditioner: two-flop synchroniser followed by a third flop
// used only for falling-edge detection. All stages reset to the idle (1) level.
// Ports:
//   sys_clk  - system clock
//   sys_rst  - synchronous active-high reset
//   rx       - asynchronous serial input
//   rx_sync  - synchronised line level (stage 2)
//   rx_fall  - one-cycle pulse, stage 3 high and stage 2 low
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic [2:0] sync_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], rx};
        end
    end

    assign rx_sync = sync_q[1];
    assign rx_fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with triple-sample majority vote per bit,
// false-start rejection, optional parity and one or two checked stop bits.
// Ports:
//   sys_clk        - system clock
//   sys_rst        - synchronous active-high reset
//   rx             - asynchronous serial line, idle high
//   po_data        - received word, bit0 = first data bit on the line
//   po_flag        - one-cycle pulse, po_data and error flags valid
//   po_parity_err  - parity mismatch for the delivered frame
//   po_frame_err   - a checked stop bit was sampled low
//   busy           - frame reception in progress
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for a falling edge, baud counter held at 0
// ST_START  | validating the start bit; high majority is a false start
// ST_DATA   | shifting in DATA_BITS data bits, LSB first
// ST_PARITY | checking the parity bit (only when parity is enabled)
// ST_STOP   | checking stop bits; frame delivered after the last one
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] po_data,
    output logic                 po_flag,
    output logic                 po_parity_err,
    output logic                 po_frame_err,
    output logic                 busy
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int CNT_W        = baud_cnt_width(CLK_FREQ, UART_BPS);
    localparam int MID          = BAUD_CNT_MAX / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] TICK_CNT = CNT_W'(MID + 2);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       PAR_EN    = (PARITY != PAR_NONE);
    // XOR over data and parity bit expected by the selected mode
    localparam logic       PAR_XOR   = (PARITY == PAR_ODD);

    logic                 rx_sync;
    logic                 rx_fall;
    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           samp;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_err;
    logic                 frm_err;
    logic                 bit_tick;
    logic                 bit_val;
    logic                 last_data;
    logic                 last_stop;

    uart_rx_sync u_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .rx      (rx),
        .rx_sync (rx_sync),
        .rx_fall (rx_fall)
    );

    assign bit_tick  = (state != ST_IDLE) && (baud_cnt == TICK_CNT);
    assign bit_val   = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    assign last_data = (bit_cnt == LAST_DATA);
    assign last_stop = (bit_cnt == LAST_STOP);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rx_fall) state_nxt = ST_START;
            end
            ST_START: begin
                if (bit_tick) state_nxt = bit_val ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick && last_data) state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_tick) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // leaving mid-way through the last stop bit lets a start edge
                // right after it be accepted
                if (bit_tick && last_stop) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            baud_cnt      <= '0;
            samp          <= 3'b111;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            par_err       <= 1'b0;
            frm_err       <= 1'b0;
            po_data       <= '0;
            po_flag       <= 1'b0;
            po_parity_err <= 1'b0;
            po_frame_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            po_flag <= 1'b0;

            if (state == ST_IDLE || state_nxt == ST_IDLE) begin
                baud_cnt <= '0;
            end else if (baud_cnt == CNT_LAST) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (baud_cnt == SMP_A) samp[0] <= rx_sync;
            if (baud_cnt == SMP_B) samp[1] <= rx_sync;
            if (baud_cnt == SMP_C) samp[2] <= rx_sync;

            case (state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        bit_cnt <= '0;
                        par_err <= 1'b0;
                        frm_err <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= last_data ? 4'd0 : bit_cnt + 4'd1;
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) par_err <= ((^shift_reg) ^ bit_val) != PAR_XOR;
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (last_stop) begin
                            po_flag       <= 1'b1;
                            po_data       <= shift_reg;
                            po_parity_err <= par_err;
                            po_frame_err  <= frm_err | ~bit_val;
                        end else begin
                            frm_err <= frm_err | ~bit_val;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
